// File: rtl/pin_bus_pkg.sv
// pin_bus_pkg: shared width limits, count type and parity helper for the scalar/bus deserializer and serializer pair
package pin_bus_pkg;
    localparam int PIN_BUS_WIDTH_MAX = 32;
    typedef logic [$clog2(PIN_BUS_WIDTH_MAX+2)-1:0] pin_bus_cnt_t;
    typedef logic [PIN_BUS_WIDTH_MAX:0] pin_bus_vec_t;
    function automatic logic pin_bus_even_par(input pin_bus_vec_t v);
        return ^v;
    endfunction
endpackage

// File: rtl/pin_bus_slot.sv
// pin_bus_slot: output register with hold flag; decides load, hold or consume of a completed word
// Ports: clk, rstb (sync active-low); load/word = word completing this cycle; held = completed word parked in the shifter;
//        err/par_err = parity error (PIN_BUS_DESER_PARITY_EN only); mid/mid_valid/mid_ready = output handshake; hold = word parked.
module pin_bus_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] held,
`ifdef PIN_BUS_DESER_PARITY_EN
    input  logic             err,
    output logic             par_err,
`endif
    input  logic             mid_ready,
    output logic [WIDTH-1:0] mid,
    output logic             mid_valid,
    output logic             hold
);
`ifdef PIN_BUS_DESER_PARITY_EN
    logic hold_err;
`endif
    // While hold is set the completed word stays in the shifter; only its parity flag is kept here.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            mid       <= '0;
            mid_valid <= 1'b0;
            hold      <= 1'b0;
`ifdef PIN_BUS_DESER_PARITY_EN
            par_err   <= 1'b0;
            hold_err  <= 1'b0;
`endif
        end else if (hold) begin
            if (mid_ready) begin
                mid  <= held;
                hold <= 1'b0;
`ifdef PIN_BUS_DESER_PARITY_EN
                par_err <= hold_err;
`endif
            end
        end else if (load && mid_valid && !mid_ready) begin
            hold <= 1'b1;
`ifdef PIN_BUS_DESER_PARITY_EN
            hold_err <= err;
`endif
        end else if (load) begin
            mid       <= word;
            mid_valid <= 1'b1;
`ifdef PIN_BUS_DESER_PARITY_EN
            par_err   <= err;
`endif
        end else if (mid_ready) begin
            mid_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pin_bus_deser.sv
// pin_bus_deser: serial-to-bus deserializer, MSB first, with valid/ready on both sides
// Ports: clk, rstb (sync active-low); vin/vin_valid/vin_sof/vin_ready = serial input; mid/mid_valid/mid_ready = bus output;
//        par_err = even-parity error, present only when PIN_BUS_DESER_PARITY_EN is defined (adds one parity bit per word).
module pin_bus_deser
    import pin_bus_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             vin,
    input  logic             vin_valid,
    input  logic             vin_sof,
    output logic             vin_ready,
    output logic [WIDTH-1:0] mid,
    output logic             mid_valid,
`ifdef PIN_BUS_DESER_PARITY_EN
    output logic             par_err,
`endif
    input  logic             mid_ready
);
`ifdef PIN_BUS_DESER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    pin_bus_cnt_t     cnt, pos;
    logic [WIDTH-1:0] sh, shb, word;
    logic             hold, acc, par_slot, restart, last;
    assign vin_ready = !hold;
    assign acc       = vin_valid && vin_ready;
`ifdef PIN_BUS_DESER_PARITY_EN
    assign par_slot  = cnt == pin_bus_cnt_t'(WIDTH);
`else
    assign par_slot  = 1'b0;
`endif
    // sof mid-word drops the partial word; the accepted bit restarts at position 0
    assign restart   = vin_sof && !par_slot && cnt != '0;
    assign pos       = restart ? '0 : cnt;
    assign last      = acc && pos == pin_bus_cnt_t'(NB - 1);
    assign shb       = restart ? '0 : sh;
    // the parity bit is not shifted in, so the shifter always holds the data word once complete
    assign word      = par_slot ? sh : {shb[WIDTH-2:0], vin};
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt <= '0;
            sh  <= '0;
        end else if (acc) begin
            cnt <= last ? '0 : pos + 1'b1;
            sh  <= word;
        end
    end
    pin_bus_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rstb      (rstb),
        .load      (last),
        .word      (word),
        .held      (sh),
`ifdef PIN_BUS_DESER_PARITY_EN
        .err       (pin_bus_even_par(pin_bus_vec_t'({sh, vin}))),
        .par_err   (par_err),
`endif
        .mid_ready (mid_ready),
        .mid       (mid),
        .mid_valid (mid_valid),
        .hold      (hold)
    );
endmodule

// File: tb/tb_pin_bus_deser.sv
// tb_pin_bus_deser: directed self-checking bench for pin_bus_deser (WIDTH=4)
module tb_pin_bus_deser;
    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       vin = 1'b0;
    logic       vin_valid = 1'b0;
    logic       vin_sof = 1'b0;
    logic       vin_ready;
    logic [3:0] mid;
    logic       mid_valid;
    logic       mid_ready = 1'b1;
`ifdef PIN_BUS_DESER_PARITY_EN
    logic       par_err;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pin_bus_deser #(.WIDTH(4)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .vin       (vin),
        .vin_valid (vin_valid),
        .vin_sof   (vin_sof),
        .vin_ready (vin_ready),
        .mid       (mid),
        .mid_valid (mid_valid),
`ifdef PIN_BUS_DESER_PARITY_EN
        .par_err   (par_err),
`endif
        .mid_ready (mid_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic s);
        vin = b;
        vin_valid = 1'b1;
        vin_sof = s;
        @(negedge clk);
    endtask

    task automatic idle();
        vin_valid = 1'b0;
        vin_sof = 1'b0;
        @(negedge clk);
    endtask

    // four data bits MSB first, plus the even-parity bit (optionally corrupted) in parity builds
    task automatic send_word(input logic [3:0] w, input logic s, input logic bad);
        for (int i = 3; i >= 0; i--) bit_in(w[i], s && i == 3);
`ifdef PIN_BUS_DESER_PARITY_EN
        bit_in((^w) ^ bad, 1'b0);
`else
        if (bad) $display("bad parity ignored without parity build");
`endif
    endtask

    initial begin
        logic [3:0] stream [3];
        stream[0] = 4'hA;
        stream[1] = 4'h5;
        stream[2] = 4'hF;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        chk("reset_mid", mid, 4'h0);
        chk("reset_mid_valid", mid_valid, 1'b0);
        chk("reset_vin_ready", vin_ready, 1'b1);
`ifdef PIN_BUS_DESER_PARITY_EN
        chk("reset_par_err", par_err, 1'b0);
`endif
        send_word(4'b1011, 1'b0, 1'b0);
        chk("w1011_mid", mid, 4'b1011);
        chk("w1011_valid", mid_valid, 1'b1);
        idle();
        chk("w1011_one_cycle", mid_valid, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 3; i >= 0; i--) begin
                bit_in(stream[k][i], 1'b0);
                chk("stream_vin_ready", vin_ready, 1'b1);
                if (i == 3 && k > 0) chk("stream_gap_valid", mid_valid, 1'b0);
            end
`ifdef PIN_BUS_DESER_PARITY_EN
            bit_in(^stream[k], 1'b0);
`endif
            chk("stream_mid", mid, {28'h0, stream[k]});
            chk("stream_valid", mid_valid, 1'b1);
        end
        idle();

        mid_ready = 1'b0;
        send_word(4'h3, 1'b0, 1'b0);
        chk("hold_first_mid", mid, 4'h3);
        chk("hold_first_ready", vin_ready, 1'b1);
        send_word(4'hC, 1'b0, 1'b0);
        chk("hold_vin_ready", vin_ready, 1'b0);
        chk("hold_mid", mid, 4'h3);
        idle();
        chk("hold_stable_mid", mid, 4'h3);
        chk("hold_stable_ready", vin_ready, 1'b0);
        mid_ready = 1'b1;
        idle();
        chk("release_mid", mid, 4'hC);
        chk("release_valid", mid_valid, 1'b1);
        chk("release_ready", vin_ready, 1'b1);
        idle();
        chk("release_drained", mid_valid, 1'b0);

        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("sof_partial_valid", mid_valid, 1'b0);
        send_word(4'b0110, 1'b1, 1'b0);
        chk("sof_mid", mid, 4'b0110);
        chk("sof_valid", mid_valid, 1'b1);
        idle();
        chk("sof_single_word", mid_valid, 1'b0);

`ifdef PIN_BUS_DESER_PARITY_EN
        send_word(4'h7, 1'b0, 1'b0);
        chk("par_good_mid", mid, 4'h7);
        chk("par_good_err", par_err, 1'b0);
        send_word(4'h7, 1'b0, 1'b1);
        chk("par_bad_mid", mid, 4'h7);
        chk("par_bad_valid", mid_valid, 1'b1);
        chk("par_bad_err", par_err, 1'b1);
        idle();
`endif

        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        rstb = 1'b0;
        idle();
        rstb = 1'b1;
        chk("rst_mid_word_valid", mid_valid, 1'b0);
        chk("rst_mid_word_ready", vin_ready, 1'b1);
        send_word(4'b0001, 1'b0, 1'b0);
        chk("rst_mid_word_mid", mid, 4'b0001);
        chk("rst_mid_word_next", mid_valid, 1'b1);
        idle();

        mid_ready = 1'b0;
        send_word(4'hF, 1'b0, 1'b0);
        send_word(4'hE, 1'b0, 1'b0);
        chk("rst_hold_pre", vin_ready, 1'b0);
        rstb = 1'b0;
        idle();
        rstb = 1'b1;
        chk("rst_hold_mid", mid, 4'h0);
        chk("rst_hold_valid", mid_valid, 1'b0);
        chk("rst_hold_ready", vin_ready, 1'b1);
        mid_ready = 1'b1;
        send_word(4'b0001, 1'b0, 1'b0);
        chk("rst_hold_next_mid", mid, 4'b0001);
        chk("rst_hold_next_valid", mid_valid, 1'b1);
        idle();
        chk("rst_hold_drained", mid_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
